// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared types and widths for the sequential multiplier.
package mul_seq_pkg;
  localparam int N_BITS = 8;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;
endpackage

// File: rtl/mul_seq_8_if.sv
// mul_seq_8_if: request/result handshake between the core and the multiplier.
interface mul_seq_8_if;
  logic start;
  logic [7:0] a;
  logic [7:0] b;
  logic ready;
  logic busy;
  logic done;
  logic [15:0] product;
  modport master(output start, a, b, input ready, busy, done, product);
  modport slave(input start, a, b, output ready, busy, done, product);
endinterface

// File: rtl/FA_8.sv
// FA_8: 8-bit ripple-carry adder; overflow is the carry out of bit 7.
module FA_8 (
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       overflow
);
  logic [8:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign sum[i] = in1[i] ^ in2[i] ^ c[i];
    assign c[i+1] = (in1[i] & in2[i]) | (c[i] & (in1[i] ^ in2[i]));
  end
  assign overflow = c[8];
endmodule

// File: rtl/mul_seq_8.sv
// mul_seq_8: 8x8 unsigned shift-add multiplier reusing one FA_8 per iteration.
// Define MUL_SEQ_EARLY_TERM_EN to finish early once the remaining multiplier bits are zero.
module mul_seq_8
  import mul_seq_pkg::*;
#(
  parameter int N_BITS = 8
) (
  input logic clk,
  input logic reset,
  mul_seq_8_if.slave bus
);
  if (N_BITS != mul_seq_pkg::N_BITS) begin : g_bad_width
    $error("mul_seq_8: N_BITS must equal the FA_8 width (8)");
  end
  mul_state_t state;
  logic [N_BITS-1:0] mcand;
  logic [2*N_BITS-1:0] p;
  logic [CNT_W-1:0] cnt;
  logic [N_BITS-1:0] sum;
  logic co;
  logic accept;
  logic fin;
  logic [2*N_BITS-1:0] p_next;
  FA_8 u_add (
    .in1(p[15:8]),
    .in2(p[0] ? mcand : 8'h00),
    .cin(1'b0),
    .sum(sum),
    .overflow(co)
  );
  assign accept = bus.start & (state != RUN);
`ifdef MUL_SEQ_EARLY_TERM_EN
  logic skip;
  // Unprocessed multiplier bits sit in p[7-cnt:0]; if all zero, shift them out in one step.
  assign skip = (p[7:0] & (8'hFF >> cnt)) == 8'h00;
  assign p_next = skip ? p >> (5'd8 - {1'b0, cnt}) : {co, sum, p[7:1]};
  assign fin = skip | (cnt == 4'd7);
`else
  assign p_next = {co, sum, p[7:1]};
  assign fin = cnt == 4'd7;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      mcand <= '0;
      p <= '0;
      cnt <= '0;
    end else if (accept) begin
      state <= RUN;
      mcand <= bus.a;
      p <= {8'h00, bus.b};
      cnt <= '0;
    end else if (state == RUN) begin
      p <= p_next;
      cnt <= cnt + 4'd1;
      state <= fin ? DONE : RUN;
    end else if (state == DONE) begin
      state <= IDLE;
    end
  end
  assign bus.ready = state != RUN;
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
  assign bus.product = p;
endmodule
